// File: rtl/ux607_tl2icb_bridge.sv
// ux607_tl2icb_bridge: TileLink-UL (A/D) responder issuing one ICB command per beat, in-order D responses.
// Optional D-channel skid buffer enabled by defining UX607_TL2ICB_RSP_BUF_EN.
`ifndef UX607_PA_SIZE
`define UX607_PA_SIZE 32
`endif

module ux607_tl2icb_bridge #(
  parameter int TL_AW      = 29,
  parameter int ICB_AW     = `UX607_PA_SIZE,
  parameter int OUTS_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              tl_a_valid_i,
  output logic              tl_a_ready_o,
  input  logic [2:0]        tl_a_opcode_i,
  input  logic [2:0]        tl_a_size_i,
  input  logic [4:0]        tl_a_source_i,
  input  logic [TL_AW-1:0]  tl_a_address_i,
  input  logic [3:0]        tl_a_mask_i,
  input  logic [31:0]       tl_a_data_i,
  output logic              tl_d_valid_o,
  input  logic              tl_d_ready_i,
  output logic [2:0]        tl_d_opcode_o,
  output logic [2:0]        tl_d_size_o,
  output logic [4:0]        tl_d_source_o,
  output logic [1:0]        tl_d_addr_lo_o,
  output logic [31:0]       tl_d_data_o,
  output logic              tl_d_error_o,
  output logic              icb_cmd_valid_o,
  input  logic              icb_cmd_ready_i,
  output logic [ICB_AW-1:0] icb_cmd_addr_o,
  output logic              icb_cmd_read_o,
  output logic [31:0]       icb_cmd_wdata_o,
  output logic [3:0]        icb_cmd_wmask_o,
  input  logic              icb_rsp_valid_i,
  output logic              icb_rsp_ready_o,
  input  logic [31:0]       icb_rsp_rdata_i,
  input  logic              icb_rsp_err_i
);
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);

  typedef struct packed {
    logic [4:0] source;
    logic [2:0] size;
    logic [1:0] addr_lo;
    logic       is_get;
    logic       local_err;
  } entry_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [4:0]  source;
    logic [1:0]  addr_lo;
    logic [31:0] data;
    logic        error;
  } dbeat_t;

  entry_t        fifo_q [OUTS_DEPTH];
  entry_t        head;
  entry_t        new_entry;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          unsup, full, empty, is_get, push, pop;
  logic          rd_valid, rd_ready;
  dbeat_t        rd_beat;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_get = (tl_a_opcode_i == 3'd4);
  assign unsup  = !((tl_a_opcode_i == 3'd0) || (tl_a_opcode_i == 3'd1) || is_get) || (tl_a_size_i > 3'd2);
  assign full   = (count_q == CW'(OUTS_DEPTH));
  assign empty  = (count_q == '0);

  assign icb_cmd_valid_o = rst_n_i & tl_a_valid_i & !full & !unsup;
  assign tl_a_ready_o    = rst_n_i & !full & (unsup | icb_cmd_ready_i);
  assign push            = tl_a_valid_i & tl_a_ready_o;

  assign icb_cmd_addr_o  = ICB_AW'(tl_a_address_i);
  assign icb_cmd_read_o  = is_get;
  assign icb_cmd_wdata_o = tl_a_data_i;

  always_comb begin
    icb_cmd_wmask_o = 4'b0000;
    case (tl_a_opcode_i)
      3'd1: icb_cmd_wmask_o = tl_a_mask_i;
      3'd0: begin
        case (tl_a_size_i)
          3'd2:    icb_cmd_wmask_o = 4'b1111;
          3'd1:    icb_cmd_wmask_o = 4'b0011 << {tl_a_address_i[1], 1'b0};
          default: icb_cmd_wmask_o = 4'b0001 << tl_a_address_i[1:0];
        endcase
      end
      default: icb_cmd_wmask_o = 4'b0000;
    endcase
  end

  assign new_entry = '{source: tl_a_source_i, size: tl_a_size_i, addr_lo: tl_a_address_i[1:0],
                       is_get: is_get, local_err: unsup};
  assign head = fifo_q[rd_ptr_q];

  // Locally-errored heads answer on their own; normal heads pass the ICB response straight through.
  always_comb begin
    rd_beat         = '0;
    rd_valid        = 1'b0;
    icb_rsp_ready_o = 1'b0;
    if (rst_n_i && !empty) begin
      rd_beat.opcode  = {2'b00, head.is_get};
      rd_beat.size    = head.size;
      rd_beat.source  = head.source;
      rd_beat.addr_lo = head.addr_lo;
      if (head.local_err) begin
        rd_valid      = 1'b1;
        rd_beat.error = 1'b1;
      end else begin
        rd_valid        = icb_rsp_valid_i;
        icb_rsp_ready_o = rd_ready;
        rd_beat.data    = head.is_get ? icb_rsp_rdata_i : 32'h0;
        rd_beat.error   = icb_rsp_err_i;
      end
    end
  end

  assign pop = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

`ifdef UX607_TL2ICB_RSP_BUF_EN
  // Two entries let a beat enter while one leaves, so ready depends only on occupancy.
  dbeat_t     buf_q [2];
  dbeat_t     buf_head;
  logic       buf_wp_q, buf_wp_d, buf_rp_q, buf_rp_d;
  logic [1:0] buf_cnt_q, buf_cnt_d;
  logic       buf_push, buf_pop;

  assign rd_ready     = (buf_cnt_q != 2'd2);
  assign buf_push     = rd_valid & rd_ready;
  assign tl_d_valid_o = rst_n_i & (buf_cnt_q != 2'd0);
  assign buf_pop      = tl_d_valid_o & tl_d_ready_i;
  assign buf_head     = buf_q[buf_rp_q];

  assign tl_d_opcode_o  = buf_head.opcode;
  assign tl_d_size_o    = buf_head.size;
  assign tl_d_source_o  = buf_head.source;
  assign tl_d_addr_lo_o = buf_head.addr_lo;
  assign tl_d_data_o    = buf_head.data;
  assign tl_d_error_o   = buf_head.error;

  always_comb begin
    buf_wp_d  = buf_wp_q;
    buf_rp_d  = buf_rp_q;
    buf_cnt_d = buf_cnt_q;
    if (buf_push) buf_wp_d = ~buf_wp_q;
    if (buf_pop)  buf_rp_d = ~buf_rp_q;
    case ({buf_push, buf_pop})
      2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      buf_wp_q  <= 1'b0;
      buf_rp_q  <= 1'b0;
      buf_cnt_q <= 2'd0;
    end else begin
      buf_wp_q  <= buf_wp_d;
      buf_rp_q  <= buf_rp_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_push) buf_q[buf_wp_q] <= rd_beat;
  end
`else
  assign rd_ready       = tl_d_ready_i;
  assign tl_d_valid_o   = rd_valid;
  assign tl_d_opcode_o  = rd_beat.opcode;
  assign tl_d_size_o    = rd_beat.size;
  assign tl_d_source_o  = rd_beat.source;
  assign tl_d_addr_lo_o = rd_beat.addr_lo;
  assign tl_d_data_o    = rd_beat.data;
  assign tl_d_error_o   = rd_beat.error;
`endif

endmodule

// File: tb/tb_ux607_tl2icb_bridge.sv
// Bench for ux607_tl2icb_bridge: directed cases plus random traffic against a queue-based model
// of outstanding TL requests and an in-order ICB slave.
module tb_ux607_tl2icb_bridge;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tl_a_valid, tl_a_ready;
  logic [2:0]  tl_a_opcode, tl_a_size;
  logic [4:0]  tl_a_source;
  logic [28:0] tl_a_address;
  logic [3:0]  tl_a_mask;
  logic [31:0] tl_a_data;
  logic        tl_d_valid, tl_d_ready;
  logic [2:0]  tl_d_opcode, tl_d_size;
  logic [4:0]  tl_d_source;
  logic [1:0]  tl_d_addr_lo;
  logic [31:0] tl_d_data;
  logic        tl_d_error;
  logic        icb_cmd_valid, icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  always #5 clk = ~clk;

  ux607_tl2icb_bridge #(.TL_AW(29), .ICB_AW(32), .OUTS_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .tl_a_valid_i(tl_a_valid), .tl_a_ready_o(tl_a_ready), .tl_a_opcode_i(tl_a_opcode),
    .tl_a_size_i(tl_a_size), .tl_a_source_i(tl_a_source), .tl_a_address_i(tl_a_address),
    .tl_a_mask_i(tl_a_mask), .tl_a_data_i(tl_a_data),
    .tl_d_valid_o(tl_d_valid), .tl_d_ready_i(tl_d_ready), .tl_d_opcode_o(tl_d_opcode),
    .tl_d_size_o(tl_d_size), .tl_d_source_o(tl_d_source), .tl_d_addr_lo_o(tl_d_addr_lo),
    .tl_d_data_o(tl_d_data), .tl_d_error_o(tl_d_error),
    .icb_cmd_valid_o(icb_cmd_valid), .icb_cmd_ready_i(icb_cmd_ready), .icb_cmd_addr_o(icb_cmd_addr),
    .icb_cmd_read_o(icb_cmd_read), .icb_cmd_wdata_o(icb_cmd_wdata), .icb_cmd_wmask_o(icb_cmd_wmask),
    .icb_rsp_valid_i(icb_rsp_valid), .icb_rsp_ready_o(icb_rsp_ready),
    .icb_rsp_rdata_i(icb_rsp_rdata), .icb_rsp_err_i(icb_rsp_err)
  );

  typedef struct {
    logic [4:0] src;
    logic [2:0] size;
    logic [1:0] lo;
    bit         is_get;
    bit         lerr;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          delay;
  } srsp_t;

  req_t  q[$];
  srsp_t sq[$];
  int    errors = 0;
  int    checks = 0;
  int    slave_max_delay = 0;
  bit    rsp_en = 1'b1;
  bit    err_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_unsup(input logic [2:0] op, input logic [2:0] size);
    return !(op == 3'd0 || op == 3'd1 || op == 3'd4) || (size > 3'd2);
  endfunction

  // Byte lanes of a naturally aligned PutFull: 2^size bytes starting at the aligned offset.
  function automatic logic [3:0] exp_mask(input logic [2:0] op, input logic [2:0] size,
                                          input logic [28:0] addr, input logic [3:0] m);
    int bytes, off;
    if (op == 3'd1) return m;
    if (op == 3'd4) return 4'b0000;
    bytes = 1 << size;
    off   = int'(addr[1:0]) & ~(bytes - 1) & 3;
    return 4'(((1 << bytes) - 1) << off);
  endfunction

  task automatic set_a(input bit v, input logic [2:0] op, input logic [2:0] size, input logic [4:0] src,
                       input logic [28:0] addr, input logic [3:0] m, input logic [31:0] d);
    tl_a_valid = v; tl_a_opcode = op; tl_a_size = size; tl_a_source = src;
    tl_a_address = addr; tl_a_mask = m; tl_a_data = d;
  endtask

  task automatic drive_slave();
    icb_rsp_valid = rsp_en && (sq.size() > 0) && (sq.size() > 0 ? sq[0].delay == 0 : 1'b0);
    icb_rsp_rdata = (sq.size() > 0) ? sq[0].rdata : $urandom;
    icb_rsp_err   = (sq.size() > 0) ? sq[0].err : 1'($urandom);
  endtask

  task automatic set_last_rsp(input logic [31:0] rdata, input bit err);
    srsp_t t;
    t = sq[sq.size() - 1];
    t.rdata = rdata;
    t.err = err;
    sq[sq.size() - 1] = t;
  endtask

  // Per-cycle compare at the falling edge, then advance the model to the next rising edge.
  task automatic tick();
    bit    uns, full, ecv, ear, edv, erv;
    req_t  h, n;
    srsp_t s;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst a_ready", tl_a_ready, 0);
      chk("rst cmd_valid", icb_cmd_valid, 0);
      chk("rst d_valid", tl_d_valid, 0);
      chk("rst rsp_ready", icb_rsp_ready, 0);
      q.delete();
      sq.delete();
    end else begin
      uns  = is_unsup(tl_a_opcode, tl_a_size);
      full = (q.size() == DEPTH);
      ecv  = tl_a_valid && !full && !uns;
      ear  = !full && (uns || icb_cmd_ready);
      chk("a_ready", tl_a_ready, ear);
      chk("cmd_valid", icb_cmd_valid, ecv);
      if (ecv) begin
        chk("cmd_addr", icb_cmd_addr, {3'b000, tl_a_address});
        chk("cmd_read", icb_cmd_read, tl_a_opcode == 3'd4);
        chk("cmd_wdata", icb_cmd_wdata, tl_a_data);
        chk("cmd_wmask", icb_cmd_wmask, exp_mask(tl_a_opcode, tl_a_size, tl_a_address, tl_a_mask));
      end
      if (q.size() == 0) begin
        edv = 1'b0; erv = 1'b0;
      end else if (q[0].lerr) begin
        edv = 1'b1; erv = 1'b0;
      end else begin
        edv = icb_rsp_valid; erv = tl_d_ready;
      end
      chk("d_valid", tl_d_valid, edv);
      chk("rsp_ready", icb_rsp_ready, erv);
      if (edv) begin
        h = q[0];
        chk("d_opcode", tl_d_opcode, {2'b00, h.is_get});
        chk("d_size", tl_d_size, h.size);
        chk("d_source", tl_d_source, h.src);
        chk("d_addr_lo", tl_d_addr_lo, h.lo);
        chk("d_data", tl_d_data, (h.lerr || !h.is_get) ? 32'h0 : sq[0].rdata);
        chk("d_error", tl_d_error, h.lerr ? 1'b1 : sq[0].err);
      end
      for (int i = 0; i < sq.size(); i++) begin
        s = sq[i];
        if (s.delay > 0) s.delay--;
        sq[i] = s;
      end
      if (edv && tl_d_ready) begin
        if (!q[0].lerr) void'(sq.pop_front());
        void'(q.pop_front());
      end
      if (tl_a_valid && ear) begin
        n.src = tl_a_source; n.size = tl_a_size; n.lo = tl_a_address[1:0];
        n.is_get = (tl_a_opcode == 3'd4); n.lerr = uns;
        q.push_back(n);
      end
      if (ecv && icb_cmd_ready) begin
        s.rdata = $urandom;
        s.err   = err_en && ($urandom_range(0, 7) == 0);
        s.delay = $urandom_range(0, slave_max_delay);
        sq.push_back(s);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] ops [8];
    ops = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd0, 3'd2, 3'd3, 3'd7};
    rst_n = 1'b0;
    set_a(1, 3'd4, 3'd2, 5'd0, 29'h0, 4'hF, 32'h0);
    icb_cmd_ready = 1'b1;
    tl_d_ready = 1'b1;
    rsp_en = 1'b0;
    drive_slave();
    #1;
    chk("reset a_ready lit", tl_a_ready, 0);
    chk("reset cmd_valid lit", icb_cmd_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    set_a(0, 3'd4, 3'd2, 5'd0, 29'h0, 4'hF, 32'h0);
    drive_slave();
    #1;
    chk("post-reset d_valid lit", tl_d_valid, 0);
    chk("post-reset rsp_ready lit", icb_rsp_ready, 0);
    tick();

    // Get 0x1004 src 5 returning DEADBEEF
    rsp_en = 1'b1;
    set_a(1, 3'd4, 3'd2, 5'd5, 29'h1004, 4'hF, 32'h0);
    drive_slave();
    #1;
    chk("get cmd_valid lit", icb_cmd_valid, 1);
    chk("get read lit", icb_cmd_read, 1);
    chk("get wmask lit", icb_cmd_wmask, 4'b0000);
    chk("get addr lit", icb_cmd_addr, 32'h1004);
    tick();
    set_a(0, 3'd4, 3'd2, 5'd0, 29'h0, 4'h0, 32'h0);
    set_last_rsp(32'hDEADBEEF, 1'b0);
    drive_slave();
    #1;
    chk("get d_valid lit", tl_d_valid, 1);
    chk("get d_opcode lit", tl_d_opcode, 3'd1);
    chk("get d_source lit", tl_d_source, 5'd5);
    chk("get d_data lit", tl_d_data, 32'hDEADBEEF);
    chk("get d_error lit", tl_d_error, 0);
    tick();

    // PutFull byte at 0x1003
    set_a(1, 3'd0, 3'd0, 5'd6, 29'h1003, 4'h0, 32'hAB000000);
    drive_slave();
    #1;
    chk("put wmask lit", icb_cmd_wmask, 4'b1000);
    chk("put read lit", icb_cmd_read, 0);
    chk("put wdata lit", icb_cmd_wdata, 32'hAB000000);
    tick();
    set_a(0, 3'd0, 3'd0, 5'd0, 29'h0, 4'h0, 32'h0);
    drive_slave();
    #1;
    chk("put d_valid lit", tl_d_valid, 1);
    chk("put d_opcode lit", tl_d_opcode, 3'd0);
    chk("put d_data lit", tl_d_data, 32'h0);
    chk("put d_error lit", tl_d_error, 0);
    tick();

    // Arithmetic opcode behind an outstanding Get
    rsp_en = 1'b0;
    set_a(1, 3'd4, 3'd2, 5'd3, 29'h2000, 4'hF, 32'h0);
    drive_slave();
    tick();
    set_a(1, 3'd2, 3'd2, 5'd7, 29'h2004, 4'hF, 32'h0);
    drive_slave();
    #1;
    chk("arith cmd_valid lit", icb_cmd_valid, 0);
    chk("arith a_ready lit", tl_a_ready, 1);
    tick();
    set_a(0, 3'd0, 3'd0, 5'd0, 29'h0, 4'h0, 32'h0);
    drive_slave();
    #1;
    chk("arith wait d_valid lit", tl_d_valid, 0);
    tick();
    rsp_en = 1'b1;
    drive_slave();
    #1;
    chk("arith prior src lit", tl_d_source, 5'd3);
    tick();
    drive_slave();
    #1;
    chk("arith d_valid lit", tl_d_valid, 1);
    chk("arith d_source lit", tl_d_source, 5'd7);
    chk("arith d_opcode lit", tl_d_opcode, 3'd0);
    chk("arith d_error lit", tl_d_error, 1);
    chk("arith rsp_ready lit", icb_rsp_ready, 0);
    tick();

    // Full FIFO stalls the third Get until the first D fires
    rsp_en = 1'b0;
    set_a(1, 3'd4, 3'd2, 5'd1, 29'h100, 4'hF, 32'h0);
    drive_slave();
    tick();
    set_a(1, 3'd4, 3'd2, 5'd2, 29'h104, 4'hF, 32'h0);
    drive_slave();
    tick();
    set_a(1, 3'd4, 3'd2, 5'd3, 29'h108, 4'hF, 32'h0);
    drive_slave();
    #1;
    chk("full a_ready lit", tl_a_ready, 0);
    chk("full cmd_valid lit", icb_cmd_valid, 0);
    tick();
    rsp_en = 1'b1;
    drive_slave();
    #1;
    chk("full first src lit", tl_d_source, 5'd1);
    chk("full no bypass lit", tl_a_ready, 0);
    tick();
    drive_slave();
    #1;
    chk("full reopen lit", tl_a_ready, 1);
    chk("full second src lit", tl_d_source, 5'd2);
    tick();
    set_a(0, 3'd0, 3'd0, 5'd0, 29'h0, 4'h0, 32'h0);
    drive_slave();
    #1;
    chk("full third src lit", tl_d_source, 5'd3);
    tick();

    // Back-to-back Gets, error on the second, d_ready 1010
    rsp_en = 1'b0;
    set_a(1, 3'd4, 3'd2, 5'd8, 29'h200, 4'hF, 32'h0);
    drive_slave();
    tick();
    set_a(1, 3'd4, 3'd2, 5'd9, 29'h204, 4'hF, 32'h0);
    drive_slave();
    tick();
    set_last_rsp(32'h0BAD0BAD, 1'b1);
    set_a(0, 3'd0, 3'd0, 5'd0, 29'h0, 4'h0, 32'h0);
    rsp_en = 1'b1;
    tl_d_ready = 1'b1;
    drive_slave();
    #1;
    chk("b2b first src lit", tl_d_source, 5'd8);
    chk("b2b first err lit", tl_d_error, 0);
    tick();
    tl_d_ready = 1'b0;
    drive_slave();
    #1;
    chk("b2b hold src lit", tl_d_source, 5'd9);
    chk("b2b hold err lit", tl_d_error, 1);
    chk("b2b hold rsp_ready lit", icb_rsp_ready, 0);
    tick();
    tl_d_ready = 1'b1;
    drive_slave();
    #1;
    chk("b2b second src lit", tl_d_source, 5'd9);
    chk("b2b second err lit", tl_d_error, 1);
    tick();
    tl_d_ready = 1'b0;
    drive_slave();
    #1;
    chk("b2b drained lit", tl_d_valid, 0);
    tick();
    tl_d_ready = 1'b1;

    // Reset with two outstanding, then a fresh Get
    rsp_en = 1'b0;
    set_a(1, 3'd4, 3'd2, 5'd10, 29'h300, 4'hF, 32'h0);
    drive_slave();
    tick();
    set_a(1, 3'd4, 3'd2, 5'd11, 29'h304, 4'hF, 32'h0);
    drive_slave();
    tick();
    rst_n = 1'b0;
    set_a(0, 3'd0, 3'd0, 5'd0, 29'h0, 4'h0, 32'h0);
    drive_slave();
    tick();
    rst_n = 1'b1;
    rsp_en = 1'b1;
    drive_slave();
    #1;
    chk("flush d_valid lit", tl_d_valid, 0);
    chk("flush rsp_ready lit", icb_rsp_ready, 0);
    set_a(1, 3'd4, 3'd2, 5'd12, 29'h3000, 4'hF, 32'h0);
    #1;
    chk("flush a_ready lit", tl_a_ready, 1);
    tick();
    set_a(0, 3'd0, 3'd0, 5'd0, 29'h0, 4'h0, 32'h0);
    set_last_rsp(32'h12345678, 1'b0);
    drive_slave();
    #1;
    chk("flush new src lit", tl_d_source, 5'd12);
    chk("flush new data lit", tl_d_data, 32'h12345678);
    tick();

    // Random traffic
    slave_max_delay = 3;
    err_en = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst_n         = ($urandom_range(0, 399) != 0);
      icb_cmd_ready = ($urandom_range(0, 3) != 0);
      tl_d_ready    = ($urandom_range(0, 3) != 0);
      rsp_en        = ($urandom_range(0, 3) != 0);
      set_a(1'($urandom_range(0, 2) != 0), ops[$urandom_range(0, 7)],
            ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
            5'($urandom), 29'($urandom), 4'($urandom), $urandom);
      drive_slave();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
